motor_driver: RTL
=================

Name: motor_driver

Overview:
- H-bridge drive stage that receives the outputs of the motor control block: the 2-bit motor command and the 8-bit velocity pattern.
- Serializes the velocity pattern into a cyclic PWM bit stream and steers it to the forward or reverse bridge input.
- Inserts a dead-time whenever the bridge must switch between conducting states, so both bridge inputs are never driven for opposite directions back-to-back.

Parameters:
- PRESCALE, 4, clock cycles per pattern bit (>=1)
- DEAD_CYCLES, 3, cycles both bridge inputs are held low on a conducting-state change (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- motor  input  2  command: 00 coast, 01 forward, 10 reverse, 11 brake
- velocity  input  8  PWM pattern, bit 0 emitted first
- in1  output  1  bridge forward input
- in2  output  1  bridge reverse input
- dead  output  1  high while in dead-time
- frame_start  output  1  one-cycle pulse when a new pattern frame is latched
- state  output  3  current FSM state code, for debug

Behaviour:
- Reset (async, immediate): state=IDLE; in1=in2=dead=frame_start=0; prescaler=0; bit index=0; pattern register=0.
- All outputs are registered. in1/in2/dead/state reflect the state and pattern bit entered on the same edge.
- Latency: one cycle from a sampled motor change to the bridge outputs.
- State codes: IDLE=0, FWD=1, REV=2, BRAKE=3, DEAD=4.
- Bridge drive per state:
  - IDLE: in1=in2=0.
  - FWD: in1=pattern[idx], in2=0.
  - REV: in1=0, in2=pattern[idx].
  - BRAKE: in1=in2=1, no PWM.
  - DEAD: in1=in2=0, dead=1.
- Transitions, evaluated every cycle on the motor input:
  - motor=00 from any state: go to IDLE next edge. This includes leaving DEAD early.
  - From IDLE: 01 goes to FWD, 10 goes to REV, 11 goes to BRAKE, each directly.
  - From FWD, REV or BRAKE, a command naming a different non-IDLE state: go to DEAD and load the dead counter with DEAD_CYCLES-1.
  - In DEAD: decrement the counter each cycle. When it is 0, go to the state named by the current motor input.
    - If that input is 00, go to IDLE.
    - DEAD therefore lasts exactly DEAD_CYCLES cycles when the command is stable.
  - A command equal to the current state is held with no effect.
- Frame handling, in FWD and REV only:
  - On entry to FWD/REV: latch velocity into the pattern register, set idx=0 and prescaler=0, pulse frame_start.
  - The prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps and idx increments.
  - When idx wraps 7->0, velocity is re-latched and frame_start pulses.
  - velocity changes mid-frame have no effect until the next frame boundary.
  - In IDLE, BRAKE and DEAD the prescaler, idx and pattern are frozen and ignored.
- Counter widths: prescaler counter is clog2(PRESCALE), minimum 1 bit; dead counter is clog2(DEAD_CYCLES), minimum 1 bit.
- velocity=0x00 in FWD/REV: outputs stay 0 and frames still cycle.
- velocity=0xFF: the active input stays high continuously.
- Reset asserted mid-frame or mid-dead-time: immediate return to reset values. No dead-time is inserted after reset release.

Test Plan:
- Reset: rst=1 with motor=01, velocity=0xFF → in1=in2=dead=0, state=0. Release → in1=1 on the first edge, frame_start=1 for one cycle.
- Forward PWM: motor=01, velocity=0x0F, PRESCALE=4 → in1 high 16 cycles, low 16, period 32; in2=0 always; frame_start every 32 cycles.
- Reversal: steady FWD, then motor=10 → dead=1 with in1=in2=0 for exactly 3 cycles, then state=2, in2 follows 0x0F from bit 0, frame_start pulses.
- Mid-frame update: FWD with 0x0F; at idx=3 set velocity=0x33 → the current frame finishes as 0x0F, and the next frame emits in1 pattern 1,1,0,0,1,1,0,0 (4 cycles each).
- Brake: IDLE→11 gives in1=in2=1 next edge. FWD→11 gives 3 dead cycles, then in1=in2=1.
- Abort: motor=00 during the second dead cycle → IDLE on the next edge, dead=0. Asserting rst mid-frame clears in1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/motor_driver.sv
// H-bridge drive stage: serializes an 8-bit velocity pattern into PWM on the
// forward or reverse bridge input, with dead-time between conducting states.
module motor_driver #(
    parameter int PRESCALE    = 4,
    parameter int DEAD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] motor,
    input  logic [7:0] velocity,
    output logic       in1,
    output logic       in2,
    output logic       dead,
    output logic       frame_start,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES - 1);

    state_t          r_state;
    logic [DW-1:0]   r_dead_cnt;
    logic [PW-1:0]   r_presc;
    logic [2:0]      r_idx;
    logic [7:0]      r_pattern;

    state_t          w_target;
    state_t          w_state_nxt;
    logic [DW-1:0]   w_dead_cnt_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      w_pattern_nxt;
    logic            w_frame_nxt;
    logic            w_bit;
    logic            w_in1_nxt;
    logic            w_in2_nxt;

    function automatic state_t cmd_state(input logic [1:0] cmd);
        case (cmd)
            2'b01:   return ST_FWD;
            2'b10:   return ST_REV;
            2'b11:   return ST_BRAKE;
            default: return ST_IDLE;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_target       = cmd_state(motor);
        w_state_nxt    = r_state;
        w_dead_cnt_nxt = r_dead_cnt;

        if (motor == 2'b00) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = w_target;
                ST_FWD, ST_REV, ST_BRAKE: begin
                    if (w_target != r_state) begin
                        w_state_nxt    = ST_DEAD;
                        w_dead_cnt_nxt = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (r_dead_cnt == '0)
                        w_state_nxt = w_target;
                    else
                        w_dead_cnt_nxt = r_dead_cnt - 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Frame sequencing only advances while driving PWM; elsewhere it stays frozen.
    always_comb begin
        w_presc_nxt   = r_presc;
        w_idx_nxt     = r_idx;
        w_pattern_nxt = r_pattern;
        w_frame_nxt   = 1'b0;

        if (w_state_nxt == ST_FWD || w_state_nxt == ST_REV) begin
            if (w_state_nxt != r_state) begin
                w_pattern_nxt = velocity;
                w_idx_nxt     = 3'd0;
                w_presc_nxt   = '0;
                w_frame_nxt   = 1'b1;
            end else if (r_presc == PRESC_LAST) begin
                w_presc_nxt = '0;
                if (r_idx == 3'd7) begin
                    w_idx_nxt     = 3'd0;
                    w_pattern_nxt = velocity;
                    w_frame_nxt   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end
    end

    always_comb begin
        w_bit     = w_pattern_nxt[w_idx_nxt];
        w_in1_nxt = 1'b0;
        w_in2_nxt = 1'b0;
        case (w_state_nxt)
            ST_FWD:   w_in1_nxt = w_bit;
            ST_REV:   w_in2_nxt = w_bit;
            ST_BRAKE: begin
                w_in1_nxt = 1'b1;
                w_in2_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are registered from next-state values so they match the state entered on the same edge.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dead_cnt  <= '0;
            r_presc     <= '0;
            r_idx       <= 3'd0;
            r_pattern   <= 8'h00;
            in1         <= 1'b0;
            in2         <= 1'b0;
            dead        <= 1'b0;
            frame_start <= 1'b0;
            state       <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_dead_cnt  <= w_dead_cnt_nxt;
            r_presc     <= w_presc_nxt;
            r_idx       <= w_idx_nxt;
            r_pattern   <= w_pattern_nxt;
            in1         <= w_in1_nxt;
            in2         <= w_in2_nxt;
            dead        <= (w_state_nxt == ST_DEAD);
            frame_start <= w_frame_nxt;
            state       <= w_state_nxt;
        end
    end

endmodule
